// File: rtl/sdram_arbiter.sv
// Three-way SDRAM port arbiter (download, CPU, background) with one transaction
// in flight, CPU-starvation protection for the background port, and a WAIT watchdog.
module sdram_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int STARVE_MAX = 8,
  parameter int WAIT_MAX   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_req,
  input  logic              dl_we,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_din,
  output logic              dl_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              bg_req,
  input  logic              bg_we,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic [7:0]        bg_din,
  output logic [7:0]        bg_dout,
  output logic              bg_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  output logic              sdram_we,
  output logic              sdram_rd,
  input  logic              sdram_ready,
  input  logic [7:0]        sdram_dout,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(WAIT_MAX);

  localparam logic [1:0] OWN_DL  = 2'd1;
  localparam logic [1:0] OWN_CPU = 2'd2;
  localparam logic [1:0] OWN_BG  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        owner;
  logic              own_we;
  logic [SW-1:0]     starve_cnt;
  logic [WW-1:0]     wait_cnt;

  logic [1:0]        win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_din;
  logic              wait_first;
  logic              ready_ok;
  logic              wait_exit;

  // Download locks out everyone; background overtakes CPU once starved.
  always_comb begin
    win = '0;
    if (dl_req)
      win = OWN_DL;
    else if (bg_req && (starve_cnt == STARVE_LIM || !cpu_req))
      win = OWN_BG;
    else if (cpu_req)
      win = OWN_CPU;
  end

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_din  = '0;
    case (win)
      OWN_DL: begin
        win_we   = dl_we;
        win_addr = dl_addr;
        win_din  = dl_din;
      end
      OWN_CPU: begin
        win_we   = cpu_we;
        win_addr = cpu_addr;
        win_din  = cpu_din;
      end
      OWN_BG: begin
        win_we   = bg_we;
        win_addr = bg_addr;
        win_din  = bg_din;
      end
      default: begin
        win_we   = 1'b0;
        win_addr = '0;
        win_din  = '0;
      end
    endcase
  end

  // wait_cnt holds the 1-based index of the current WAIT cycle.
  assign wait_first = (wait_cnt == WW'(1));
  assign ready_ok   = !wait_first && sdram_ready;
  assign wait_exit  = ready_ok || (wait_cnt == WAIT_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win != '0) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (wait_exit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= '0;
      own_we      <= 1'b0;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      cpu_dout    <= '0;
      bg_dout     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win != '0) begin
            owner      <= win;
            own_we     <= win_we;
            sdram_addr <= win_addr;
            sdram_din  <= win_din;
            if (win == OWN_BG)
              starve_cnt <= '0;
            else if (win == OWN_CPU && bg_req && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        S_ISSUE: wait_cnt <= WW'(1);
        S_WAIT: begin
          if (wait_exit) begin
            if (!ready_ok)
              timeout_err <= 1'b1;
            if (!own_we) begin
              if (owner == OWN_CPU)
                cpu_dout <= sdram_dout;
              else if (owner == OWN_BG)
                bg_dout <= sdram_dout;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_DONE: owner <= '0;
        default: owner <= '0;
      endcase
    end
  end

  assign grant    = owner;
  assign sdram_we = (state == S_ISSUE) && own_we;
  assign sdram_rd = (state == S_ISSUE) && !own_we;
  assign dl_ack   = (state == S_DONE) && (owner == OWN_DL);
  assign cpu_ack  = (state == S_DONE) && (owner == OWN_CPU);
  assign bg_ack   = (state == S_DONE) && (owner == OWN_BG);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: table-driven single transactions, directed arbitration /
// timeout / reset sequences, then random traffic against a timeline-level model.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int SM = 8;
  localparam int WM = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          dl_req, dl_we, cpu_req, cpu_we, bg_req, bg_we;
  logic [AW-1:0] dl_addr, cpu_addr, bg_addr;
  logic [7:0]    dl_din, cpu_din, bg_din;
  logic          dl_ack, cpu_ack, bg_ack;
  logic [7:0]    cpu_dout, bg_dout;
  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_din;
  logic          sdram_we, sdram_rd, sdram_ready;
  logic [7:0]    sdram_dout;
  logic [1:0]    grant;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  sdram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset),
    .dl_req(dl_req), .dl_we(dl_we), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .bg_req(bg_req), .bg_we(bg_we), .bg_addr(bg_addr), .bg_din(bg_din),
    .bg_dout(bg_dout), .bg_ack(bg_ack),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_we(sdram_we), .sdram_rd(sdram_rd),
    .sdram_ready(sdram_ready), .sdram_dout(sdram_dout),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    req;      // {dl, cpu, bg}
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    int            lat;      // WAIT cycles before completion (>= 2)
    logic [7:0]    rdata;
    logic [1:0]    exp_grant;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] exp_cpu, exp_bg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    dl_req = 0; dl_we = 0; dl_addr = '0; dl_din = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    bg_req = 0; bg_we = 0; bg_addr = '0; bg_din = '0;
    sdram_ready = 0; sdram_dout = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    exp_cpu = '0;
    exp_bg  = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [AW+8:0] hit, miss;
    logic [2:0]    ackv;
    hit  = {v.we, v.addr, v.din};
    miss = ~hit;
    dl_req = v.req[2]; cpu_req = v.req[1]; bg_req = v.req[0];
    {dl_we, dl_addr, dl_din}    = (v.exp_grant == 2'd1) ? hit : miss;
    {cpu_we, cpu_addr, cpu_din} = (v.exp_grant == 2'd2) ? hit : miss;
    {bg_we, bg_addr, bg_din}    = (v.exp_grant == 2'd3) ? hit : miss;
    sdram_ready = 0;
    for (int c = 1; c <= v.lat + 3; c++) begin
      @(negedge clk);
      ackv = '0;
      if (c == v.lat + 2) ackv[3 - v.exp_grant] = 1'b1;
      chk($sformatf("vec%0d_c%0d_ctl", idx, c),
          {grant, sdram_we, sdram_rd, dl_ack, cpu_ack, bg_ack},
          {(c <= v.lat + 2) ? v.exp_grant : 2'd0, c == 1 && v.we, c == 1 && !v.we, ackv});
      if (c <= v.lat + 2)
        chk($sformatf("vec%0d_c%0d_addr", idx, c), {sdram_addr, sdram_din}, {v.addr, v.din});
      if (c == v.lat + 2) begin
        if (!v.we && v.exp_grant == 2'd2) exp_cpu = v.rdata;
        if (!v.we && v.exp_grant == 2'd3) exp_bg = v.rdata;
        chk($sformatf("vec%0d_dout", idx), {cpu_dout, bg_dout}, {exp_cpu, exp_bg});
        dl_req = 0; cpu_req = 0; bg_req = 0;
      end
      sdram_ready = (c == 1 || c == 2 || c == v.lat + 1);
      sdram_dout  = (c == v.lat + 1) ? v.rdata : 8'(c * 37);
    end
  endtask

  // Random-phase model: transaction timeline measured from the grant decision.
  int            off, lat, who, starve;
  logic          mwe, exp_to, cpu_known, bg_known;
  logic [7:0]    mrd, mdin;
  logic [AW-1:0] maddr;
  logic          rq[1:3], rwe[1:3];
  logic [AW-1:0] raddr[1:3];
  logic [7:0]    rdin[1:3];

  task automatic new_fields(input int r);
    rwe[r]   = 1'($urandom_range(0, 1));
    raddr[r] = AW'($urandom());
    rdin[r]  = 8'($urandom());
  endtask

  initial begin
    int n, ackc, w, ackd;
    logic [1:0] g[$];
    logic seen;

    vecs[0] = '{3'b010, 1'b0, 25'h0000123, 8'h00, 2, 8'hA5, 2'd2};
    vecs[1] = '{3'b001, 1'b1, 25'h1FFFFFF, 8'h3C, 4, 8'h11, 2'd3};
    vecs[2] = '{3'b111, 1'b1, 25'h0000010, 8'h55, 3, 8'h22, 2'd1};
    vecs[3] = '{3'b011, 1'b0, 25'h0ABCDEF, 8'h00, 2, 8'h5A, 2'd2};
    vecs[4] = '{3'b001, 1'b0, 25'h1234567, 8'h00, 5, 8'hC3, 2'd3};
    vecs[5] = '{3'b101, 1'b0, 25'h0F0F0F0, 8'h00, 2, 8'h77, 2'd1};
    vecs[6] = '{3'b110, 1'b1, 25'h0000001, 8'h99, 6, 8'h33, 2'd1};

    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset_state",
        {grant, dl_ack, cpu_ack, bg_ack, sdram_we, sdram_rd, sdram_addr, sdram_din, cpu_dout, bg_dout, timeout_err},
        '0);
    reset = 0;
    exp_cpu = '0;
    exp_bg  = '0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Download mode blocks CPU until dl_req drops.
    do_reset();
    sdram_ready = 1;
    dl_req = 1; dl_we = 1; cpu_req = 1; cpu_we = 0;
    g.delete();
    for (int c = 0; c < 200 && g.size() < 4; c++) begin
      @(negedge clk);
      if (sdram_we || sdram_rd) g.push_back(grant);
      if (dl_ack && g.size() >= 3) dl_req = 0;
    end
    chk("dl_lock_count", g.size(), 4);
    for (int i = 0; i < g.size(); i++)
      chk($sformatf("dl_lock_g%0d", i), g[i], (i < 3) ? 2'd1 : 2'd2);
    cpu_req = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = cpu_ack;
    end
    chk("dropped_req_still_acked", seen, 1);

    // Starvation: 8 CPU grants then 1 background grant, repeating.
    do_reset();
    sdram_ready = 1;
    cpu_req = 1; bg_req = 1; cpu_we = 0; bg_we = 1;
    g.delete();
    for (int c = 0; c < 300 && g.size() < 18; c++) begin
      @(negedge clk);
      if (sdram_we || sdram_rd) g.push_back(grant);
    end
    chk("starve_count", g.size(), 18);
    for (int i = 0; i < g.size(); i++)
      chk($sformatf("starve_g%0d", i), g[i], (i % 9 == 8) ? 2'd3 : 2'd2);
    cpu_req = 0; bg_req = 0;
    repeat (8) @(negedge clk);

    // WAIT watchdog.
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 25'h0000042; cpu_din = 8'hE7;
    ackc = -1;
    for (int c = 1; c < 400 && ackc < 0; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        ackc = c;
        chk("timeout_flag_at_ack", timeout_err, 1);
        cpu_req = 0;
      end
    end
    chk("timeout_ack_cycle", ackc, WM + 2);
    chk("timeout_cpu_dout_held", cpu_dout, 8'h00);
    sdram_ready = 1;
    cpu_req = 1; cpu_we = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = cpu_ack;
      if (seen) cpu_req = 0;
    end
    chk("post_timeout_ack", seen, 1);
    @(negedge clk);
    chk("timeout_sticky", timeout_err, 1);

    // Random traffic against the timeline model.
    do_reset();
    off = 0; lat = 2; who = 0; starve = 0; mwe = 0; exp_to = 0;
    cpu_known = 1; bg_known = 1; maddr = '0; mdin = '0; mrd = '0;
    for (int r = 1; r <= 3; r++) begin
      rq[r] = 0;
      new_fields(r);
    end
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      ackd = (off == lat + 2) ? who : 0;
      chk("rand_ctl",
          {grant, sdram_we, sdram_rd, dl_ack, cpu_ack, bg_ack, timeout_err},
          {(off > 0) ? 2'(who) : 2'd0, off == 1 && mwe, off == 1 && !mwe,
           ackd == 1, ackd == 2, ackd == 3, exp_to});
      chk("rand_addr", {sdram_addr, sdram_din}, {maddr, mdin});
      if (cpu_known) chk("rand_cpu_dout", cpu_dout, exp_cpu);
      if (bg_known)  chk("rand_bg_dout", bg_dout, exp_bg);

      sdram_dout = 8'($urandom());
      if (off >= 3 && off <= lat + 1)
        sdram_ready = (off == lat + 1 && lat < WM);
      else
        sdram_ready = 1'($urandom_range(0, 1));
      if (off == lat + 1) mrd = sdram_dout;

      for (int r = 1; r <= 3; r++) begin
        if (off > 0 && r == who) begin
          if (off == lat + 2) begin
            rq[r] = 1'($urandom_range(0, 1));
            new_fields(r);
          end else if (off >= 2 && rq[r] && $urandom_range(0, 7) == 0) begin
            rq[r] = 0;
          end
        end else if (!rq[r] && $urandom_range(0, (r == 1) ? 15 : 3) == 0) begin
          rq[r] = 1;
          new_fields(r);
        end
      end
      dl_req = rq[1]; dl_we = rwe[1]; dl_addr = raddr[1]; dl_din = rdin[1];
      cpu_req = rq[2]; cpu_we = rwe[2]; cpu_addr = raddr[2]; cpu_din = rdin[2];
      bg_req = rq[3]; bg_we = rwe[3]; bg_addr = raddr[3]; bg_din = rdin[3];

      if (off == 0) begin
        w = 0;
        if (rq[1]) w = 1;
        else if (rq[3] && (starve == SM || !rq[2])) w = 3;
        else if (rq[2]) w = 2;
        if (w != 0) begin
          if (w == 2 && rq[3]) starve = (starve < SM) ? starve + 1 : SM;
          if (w == 3) starve = 0;
          who = w; mwe = rwe[w]; maddr = raddr[w]; mdin = rdin[w];
          lat = ($urandom_range(0, 39) == 0) ? WM : $urandom_range(2, 6);
          off = 1;
        end
      end else if (off == lat + 1) begin
        if (lat == WM) exp_to = 1;
        if (!mwe && who == 2) begin exp_cpu = mrd; cpu_known = (lat < WM); end
        if (!mwe && who == 3) begin exp_bg = mrd; bg_known = (lat < WM); end
        off++;
      end else if (off == lat + 2) begin
        off = 0;
      end else begin
        off++;
      end
    end

    // Reset pulsed mid-WAIT abandons the transaction.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0000777;
    repeat (3) @(negedge clk);
    chk("pre_reset_grant", grant, 2'd2);
    reset = 1;
    @(negedge clk);
    chk("mid_reset_outputs",
        {grant, dl_ack, cpu_ack, bg_ack, sdram_we, sdram_rd, sdram_addr, sdram_din, cpu_dout, bg_dout, timeout_err},
        '0);
    reset = 0;
    cpu_req = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | cpu_ack | dl_ack | bg_ack | (grant != 2'd0);
    end
    chk("post_reset_quiet", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, the SDRAM byte-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 8, the consecutive CPU grants allowed while bg_req is pending.
REQ-003 SHALL have parameter WAIT_MAX, default 255, the maximum WAIT cycles before timeout.
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- dl_req  in  1  download/upload request; level, held until ack.
- dl_we  in  1  download write enable.
- dl_addr  in  ADDR_W  download address.
- dl_din  in  8  download write data.
- dl_ack  out  1  download completion pulse.
- cpu_req  in  1  CPU slot-memory request; level, held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, registered.
- cpu_ack  out  1  CPU completion pulse.
- bg_req  in  1  background (FDC cache / block copy) request; level, held until ack.
- bg_we  in  1  background write enable.
- bg_addr  in  ADDR_W  background address.
- bg_din  in  8  background write data.
- bg_dout  out  8  background read data, registered.
- bg_ack  out  1  background completion pulse.
- sdram_addr  out  ADDR_W  SDRAM address.
- sdram_din  out  8  SDRAM write data.
- sdram_we  out  1  SDRAM write strobe.
- sdram_rd  out  1  SDRAM read strobe.
- sdram_ready  in  1  SDRAM idle/complete level.
- sdram_dout  in  8  SDRAM read data.
- grant  out  2  owner: 0 none, 1 dl, 2 cpu, 3 bg.
- timeout_err  out  1  sticky WAIT timeout flag.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one transaction outstanding.
REQ-006 IDLE SHALL sample requests and select a winner; no request keeps IDLE and grant=0.
REQ-007 Priority SHALL be dl > cpu > bg, except that bg SHALL win over cpu when starve_cnt == STARVE_MAX.
REQ-008 While dl_req=1, cpu and bg SHALL never be granted (download mode).
REQ-009 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cpu grant made while bg_req=1, and clear on a bg grant.
REQ-010 On entering ISSUE, the winner's addr/din/we SHALL be latched into sdram_addr/sdram_din and held unchanged through WAIT and DONE.
REQ-011 ISSUE SHALL assert exactly one of sdram_we/sdram_rd for exactly one cycle.
REQ-012 WAIT SHALL ignore sdram_ready on its first cycle, then exit to DONE on the first cycle sdram_ready=1.
REQ-013 A read SHALL capture sdram_dout into the winner's dout on the WAIT->DONE edge; the other dout SHALL hold its value.
REQ-014 DONE SHALL pulse the winner's ack for exactly one cycle; grant SHALL stay valid from ISSUE through DONE.
REQ-015 A req still high after its ack SHALL be treated as a new transaction and re-arbitrated in the following IDLE cycle.
REQ-016 Minimum latency SHALL be 4 cycles from req sampled in IDLE to ack when sdram_ready rises at the earliest point.
REQ-017 WAIT lasting WAIT_MAX cycles SHALL set timeout_err and go to DONE with ack; read data in that case is undefined.
REQ-018 A requester dropping req before its ack SHALL not abort the in-flight transaction; its ack still pulses.
REQ-019 Simultaneous requests SHALL resolve by REQ-007 in the same IDLE cycle, with no idle cycle inserted.

Reset
REQ-020 Reset SHALL force IDLE, grant=0, all acks/strobes=0, sdram_addr/din=0, cpu_dout/bg_dout=0, starve_cnt=0, timeout_err=0.
REQ-021 Reset mid-transaction SHALL abandon it without an ack; timeout_err SHALL clear only on reset.

Verification
- cpu_req read, addr 0x00123, sdram_ready rises on 2nd WAIT cycle, sdram_dout=0xA5 -> single sdram_rd pulse, cpu_dout=0xA5, cpu_ack 1 cycle, 4-cycle latency.
- dl_req and cpu_req asserted same cycle, both held -> only dl granted while dl_req=1; cpu granted after dl_req drops.
- cpu_req and bg_req held continuously -> 8 cpu grants, then 1 bg grant, pattern repeats.
- bg write 0x3C at 0x1FFFFFF -> sdram_we 1 cycle, sdram_addr/din stable until bg_ack, cpu_dout unchanged.
- sdram_ready held 0 -> after 255 WAIT cycles timeout_err=1 and ack pulses; stays 1 until reset.
- reset pulsed during WAIT -> next cycle grant=0, no ack, all outputs 0.
